// File: rtl/ddc_pkg.sv
// Shared types and helpers for the DDC sample packer: phase encoding,
// stream widths and the optional I/Q byte-reversal.
package ddc_pkg;

    localparam int unsigned SAMPLE_BITS = 48;
    localparam int unsigned WORD_BITS   = 64;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;

    // Reverse the three bytes of I and of Q independently.
    function automatic logic [SAMPLE_BITS-1:0] iq_byteswap(input logic [SAMPLE_BITS-1:0] x);
        return {x[31:24], x[39:32], x[47:40], x[7:0], x[15:8], x[23:16]};
    endfunction

endpackage

// File: rtl/ddc_sample_packer.sv
// Packs 48-bit I/Q samples densely into 64-bit words (4 samples -> 3 words).
// Optional macro DDC_PACKER_BYTESWAP_EN adds a byteswap input for big-endian samples.
module ddc_sample_packer
    import ddc_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned COUNT_W  = 32
) (
    input  logic                   aclk,
    input  logic                   rst,
`ifdef DDC_PACKER_BYTESWAP_EN
    input  logic                   byteswap,
`endif
    input  logic [SAMPLE_BITS-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [WORD_BITS-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic                   flush,
    output logic [COUNT_W-1:0]     word_count,
    output logic                   busy
);

    // The packing slices below are hard-wired for 24-bit I and Q.
    if (SAMPLE_W != SAMPLE_BITS / 2) begin : g_width_check
        $error("ddc_sample_packer: SAMPLE_W must be 24");
    end

    phase_t                  r_phase;
    logic [SAMPLE_BITS-1:0]  r_res;
    logic [WORD_BITS-1:0]    r_data;
    logic                    r_valid;
    logic [COUNT_W-1:0]      r_count;
    logic                    r_flush_pend;

    logic [SAMPLE_BITS-1:0]  w_sample;
    logic                    w_hs;
    logic                    w_flush_svc;

`ifdef DDC_PACKER_BYTESWAP_EN
    assign w_sample = byteswap ? iq_byteswap(s_axis_tdata) : s_axis_tdata;
`else
    assign w_sample = s_axis_tdata;
`endif

    // The output slot is free when empty or being drained this cycle.
    assign s_axis_tready = ~r_valid | m_axis_tready;
    assign w_hs          = s_axis_tvalid & s_axis_tready;
    assign w_flush_svc   = r_flush_pend & ~w_hs & s_axis_tready;

    assign m_axis_tdata  = r_data;
    assign m_axis_tvalid = r_valid;
    assign word_count    = r_count;
    assign busy          = (r_phase != P0) | r_valid;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_phase      <= P0;
            r_res        <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_count      <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (flush) begin
                r_flush_pend <= 1'b1;
            end else if (w_flush_svc) begin
                r_flush_pend <= 1'b0;
            end

            if (r_valid && m_axis_tready) begin
                r_count <= r_count + COUNT_W'(1);
                r_valid <= 1'b0;
            end

            if (w_hs) begin
                // Residue always sits right-aligned in r_res with zero upper bits.
                case (r_phase)
                    P0: begin
                        r_res   <= w_sample;
                        r_phase <= P1;
                    end
                    P1: begin
                        r_data  <= {w_sample[15:0], r_res};
                        r_valid <= 1'b1;
                        r_res   <= {16'h0, w_sample[47:16]};
                        r_phase <= P2;
                    end
                    P2: begin
                        r_data  <= {w_sample[31:0], r_res[31:0]};
                        r_valid <= 1'b1;
                        r_res   <= {32'h0, w_sample[47:32]};
                        r_phase <= P3;
                    end
                    P3: begin
                        r_data  <= {w_sample, r_res[15:0]};
                        r_valid <= 1'b1;
                        r_res   <= '0;
                        r_phase <= P0;
                    end
                endcase
            end else if (w_flush_svc) begin
                if (r_phase != P0) begin
                    r_data  <= {16'h0, r_res};
                    r_valid <= 1'b1;
                end
                r_res   <= '0;
                r_phase <= P0;
            end
        end
    end

endmodule

// File: tb/tb_ddc_sample_packer.sv
// Scoreboard bench for ddc_sample_packer: directed streams, back-pressure,
// flush, asynchronous reset and (with DDC_PACKER_BYTESWAP_EN) byte swapping.
module tb_ddc_sample_packer;

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] word_count;
    logic        busy;
`ifdef DDC_PACKER_BYTESWAP_EN
    logic        byteswap = 1'b0;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [63:0] exp_q[$];
    bit          toggle_rdy = 1'b0;

    always #4 aclk = ~aclk;

    ddc_sample_packer #(.SAMPLE_W(24), .COUNT_W(32)) dut (
        .aclk          (aclk),
        .rst           (rst),
`ifdef DDC_PACKER_BYTESWAP_EN
        .byteswap      (byteswap),
`endif
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .flush         (flush),
        .word_count    (word_count),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops on every output handshake and checks stall behaviour.
    logic [63:0] held_data;
    bit          held_v = 1'b0;
    always @(negedge aclk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
                chk("stall_data", m_axis_tdata, held_data);
            end
            held_v = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", m_axis_tdata, 64'hx);
                end else begin
                    chk("word", m_axis_tdata, exp_q.pop_front());
                end
            end else if (m_axis_tvalid) begin
                held_v    = 1'b1;
                held_data = m_axis_tdata;
                chk("s_tready_stall", 64'(s_axis_tready), 64'd0);
            end
        end
    end

    // Optional back-pressure pattern: toggle m_axis_tready every clock.
    always @(posedge aclk) begin
        #1;
        if (toggle_rdy) m_axis_tready = ~m_axis_tready;
    end

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        flush = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1 rst = 1'b0;
    endtask

    // Present one sample and hold it until a handshake is seen.
    task automatic send(input logic [47:0] d);
        bit ok;
        int budget;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        ok = 1'b0;
        budget = 50;
        while (!ok && budget > 0) begin
            @(negedge aclk);
            ok = s_axis_tready;
            @(posedge aclk);
            #1;
            budget--;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge aclk);
        #1 flush = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge aclk);
            budget--;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge aclk);
    endtask

    task automatic send_four();
        send(48'h111111_000000);
        send(48'h333333_222222);
        send(48'h555555_444444);
        send(48'h777777_666666);
    endtask

    task automatic push_four();
        exp_q.push_back(64'h2222_111111_000000);
        exp_q.push_back(64'h55444444_33333322);
        exp_q.push_back(64'h777777_666666_5555);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        @(negedge aclk);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_count", 64'(word_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd1);
        @(posedge aclk);
        #1;

        // Back-to-back, full throughput
        push_four();
        send_four();
        wait_drain();
        chk("t1_count", 64'(word_count), 64'd3);
        chk("t1_busy", 64'(busy), 64'd0);

        // Same stream under toggled back-pressure
        do_reset();
        toggle_rdy = 1'b1;
        push_four();
        send_four();
        wait_drain();
        toggle_rdy = 1'b0;
        @(posedge aclk);
        #1 m_axis_tready = 1'b1;
        @(negedge aclk);
        chk("t2_count", 64'(word_count), 64'd3);
        chk("t2_busy", 64'(busy), 64'd0);
        @(posedge aclk);
        #1;

        // One sample then flush
        do_reset();
        exp_q.push_back(64'h0000_ABCDEF_123456);
        send(48'hABCDEF_123456);
        @(negedge aclk);
        chk("t3_busy_residue", 64'(busy), 64'd1);
        @(posedge aclk);
        #1;
        pulse_flush();
        wait_drain();
        chk("t3_count", 64'(word_count), 64'd1);
        chk("t3_busy", 64'(busy), 64'd0);

        // Two samples then flush, then a flush in P0
        do_reset();
        exp_q.push_back(64'h2222_111111_000000);
        exp_q.push_back(64'h00000000_33333322);
        send(48'h111111_000000);
        send(48'h333333_222222);
        pulse_flush();
        wait_drain();
        chk("t4_count", 64'(word_count), 64'd2);
        @(posedge aclk);
        #1;
        pulse_flush();
        repeat (5) @(negedge aclk);
        chk("t4_p0_count", 64'(word_count), 64'd2);
        chk("t4_p0_tvalid", 64'(m_axis_tvalid), 64'd0);
        @(posedge aclk);
        #1;

        // Asynchronous reset in P2 with a word pending
        do_reset();
        m_axis_tready = 1'b0;
        send(48'h111111_000000);
        send(48'h333333_222222);
        @(negedge aclk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t5_async_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t5_async_busy", 64'(busy), 64'd0);
        @(posedge aclk);
        @(posedge aclk);
        #1 rst = 1'b0;
        m_axis_tready = 1'b1;
        push_four();
        send_four();
        wait_drain();
        chk("t5_count", 64'(word_count), 64'd3);

`ifdef DDC_PACKER_BYTESWAP_EN
        // Byte-swapped sample, closed by flush
        do_reset();
        byteswap = 1'b1;
        exp_q.push_back(64'h0000_030201_060504);
        send(48'h010203_040506);
        pulse_flush();
        wait_drain();
        chk("t6_count", 64'(word_count), 64'd1);
        byteswap = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
